// File: rtl/uart_seq_pkg.sv
// Shared definitions for the UART command sequencer.
//   OP_* : command / UART ren_wen encoding (0 NOP, 1 WRITE, 2 READ, 3 CLEAR)
//   state_t : sequencer FSM states
//   GAP_CNT_W : width of the inter-operation gap counter
package uart_seq_pkg;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/uart_cmd_sequencer.sv
// Command-side front end for the tapeout UART.
// Turns a valid/ready command stream into the UART's edge-triggered control
// word {ren_wen[1:0], rate_sel[1:0]}, keeps tx data stable across the UART's
// registered strobe, enforces an idle gap between operations and returns
// captured rx bytes on a valid/ready response port.
//
// Ports:
//   clk, nReset           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_op (0 NOP,1 WRITE,2 READ,3 CLEAR)
//   cmd_wdata             byte sent on WRITE
//   rate_sel              baud select, forwarded to uart_control[1:0]
//   rsp_valid/rsp_ready   response handshake; rsp_data holds the captured byte
//   uart_control          [3:2] op, [1:0] rate, to the UART
//   uart_tx_data          byte presented to the UART
//   uart_rx_data          UART rx byte, valid the cycle after a READ is registered
//   busy                  high whenever the sequencer is not IDLE
//
// GAP_CYCLES: zero-op cycles after each operation, legal range 1..15.
module uart_cmd_sequencer
  import uart_seq_pkg::*;
#(
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_wdata,
  input  logic [1:0] rate_sel,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [3:0] uart_control,
  output logic [7:0] uart_tx_data,
  input  logic [7:0] uart_rx_data,
  output logic       busy
);

  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP_CYCLES - 1);

  state_t                 state;
  logic [1:0]             ctrl_op;   // latched op, doubles as control[3:2]
  logic [1:0]             rate_q;
  logic [GAP_CNT_W-1:0]   gap_cnt;
  logic                   accept;

  // Ready depends on registered state only, never on cmd_valid.
  assign cmd_ready    = (state == IDLE) && !rsp_valid;
  assign accept       = cmd_valid && cmd_ready;
  assign busy         = (state != IDLE);
  assign uart_control = {ctrl_op, rate_q};

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state        <= IDLE;
      ctrl_op      <= OP_NOP;
      rate_q       <= 2'b00;
      gap_cnt      <= '0;
      uart_tx_data <= 8'h00;
      rsp_valid    <= 1'b0;
      rsp_data     <= 8'h00;
    end else begin
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      case (state)
        // Baud select tracks the input only while idle; it is frozen for the
        // whole operation so the UART never sees a mid-frame rate change.
        IDLE: begin
          rate_q <= rate_sel;
          if (accept && (cmd_op != OP_NOP)) begin
            ctrl_op <= cmd_op;
            state   <= ISSUE;
            if (cmd_op == OP_WRITE) begin
              uart_tx_data <= cmd_wdata;
            end
          end
        end

        // The UART registers the 0->op edge at the end of this cycle.
        ISSUE: begin
          state <= HOLD;
        end

        // Op stays asserted so no second edge is seen; rx data is valid now.
        HOLD: begin
          ctrl_op <= OP_NOP;
          gap_cnt <= GAP_LOAD;
          state   <= GAP;
          if (ctrl_op == OP_READ) begin
            rsp_data  <= uart_rx_data;
            rsp_valid <= 1'b1;
          end
        end

        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Scoreboard bench for uart_cmd_sequencer: stimulus pushes expected UART
// operations and responses into queues; independent monitors pop and compare.
module tb_uart_cmd_sequencer;
  import uart_seq_pkg::*;

  localparam int GAP = 3;

  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_wdata = 8'h00;
  logic [1:0] rate_sel = 2'b00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic [3:0] uart_control;
  logic [7:0] uart_tx_data;
  logic [7:0] uart_rx = 8'hFF;
  logic       busy;

  uart_cmd_sequencer #(.GAP_CYCLES(GAP)) dut (
    .clk          (clk),
    .nReset       (nReset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_wdata    (cmd_wdata),
    .rate_sel     (rate_sel),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .uart_control (uart_control),
    .uart_tx_data (uart_tx_data),
    .uart_rx_data (uart_rx),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  typedef struct packed {
    logic [1:0] op;
    logic [1:0] rate;
    logic [7:0] tx;
  } op_rec_t;

  op_rec_t    ops_q[$];
  logic [7:0] rsp_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] last_wdata = 8'h00;
  logic [7:0] last_rd = 8'h00;

  logic rr_random = 1'b0;
  logic rr_force  = 1'b1;

  task automatic model_accept(input logic [1:0] op, input logic [7:0] wd,
                              input logic [1:0] rs, input logic [7:0] rb);
    op_rec_t rec;
    if (op != OP_NOP) begin
      if (op == OP_WRITE) last_wdata = wd;
      rec.op = op;
      rec.rate = rs;
      rec.tx = last_wdata;
      ops_q.push_back(rec);
      if (op == OP_READ) begin
        rd_q.push_back(rb);
        rsp_q.push_back(rb);
        last_rd = rb;
      end
    end
  endtask

  // Present one command and hold it until accepted; returns 1ns after the
  // accepting edge with cmd_valid still high.
  task automatic send(input logic [1:0] op, input logic [7:0] wd,
                      input logic [1:0] rs, input logic [7:0] rb, input bit wobble);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_wdata = wd;
    rate_sel  = rs;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        model_accept(op, wd, rate_sel, rb);
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
      if (wobble && $urandom_range(0, 2) == 0) rate_sel = 2'($urandom_range(0, 3));
    end
    check("accept_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy && !rsp_valid && rsp_q.size() == 0) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    check("idle_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- response ready driver ----------------
  always @(posedge clk) begin
    #2;
    rsp_ready = rr_random ? ($urandom_range(0, 3) != 0) : rr_force;
  end

  // ---------------- UART rx model ----------------
  // A READ is registered at the end of its first op cycle; the byte is
  // presented only in the following cycle, 0xFF at all other times.
  logic [1:0] u_prev = 2'd0;
  logic       u_arm = 1'b0;
  logic [7:0] u_byte = 8'h00;
  always @(posedge clk) begin
    #1;
    if (!nReset) begin
      u_prev  = 2'd0;
      u_arm   = 1'b0;
      uart_rx = 8'hFF;
    end else begin
      if (u_arm) begin
        uart_rx = u_byte;
        u_arm   = 1'b0;
      end else begin
        uart_rx = 8'hFF;
      end
      if (uart_control[3:2] == OP_READ && u_prev == OP_NOP && rd_q.size() > 0) begin
        u_byte = rd_q.pop_front();
        u_arm  = 1'b1;
      end
      u_prev = uart_control[3:2];
    end
  end

  // ---------------- monitor ----------------
  logic [1:0] m_prev = 2'd0;
  int         m_width = 0;
  int         m_gap = 0;
  bit         m_in_gap = 0;
  bit         m_rate_ok = 1;
  logic [1:0] m_rate = 2'd0;
  bit         m_armed = 0;
  int         m_lat = 0;
  int         m_exp_lat = 0;

  always @(negedge clk) begin
    op_rec_t    rec;
    logic [7:0] exp_b;
    logic [1:0] op;
    if (!nReset) begin
      m_prev = 2'd0; m_width = 0; m_gap = 0; m_in_gap = 0;
      m_rate_ok = 1; m_armed = 0; m_lat = 0;
    end else begin
      op = uart_control[3:2];
      if (op != OP_NOP) begin
        if (m_prev == OP_NOP) begin
          if (ops_q.size() == 0) begin
            check("unexpected_op", 32'(op), 32'd0);
          end else begin
            rec = ops_q.pop_front();
            check("op_code", 32'(op), 32'(rec.op));
            check("op_rate", 32'(uart_control[1:0]), 32'(rec.rate));
            check("tx_data", 32'(uart_tx_data), 32'(rec.tx));
            m_rate = rec.rate;
          end
          m_width = 1;
          m_rate_ok = 1;
        end else begin
          m_width = (op == m_prev) ? m_width + 1 : 99;
        end
        if (uart_control[1:0] != m_rate) m_rate_ok = 0;
      end else begin
        if (m_prev != OP_NOP) begin
          check("pulse_width", 32'(m_width), 32'd2);
          m_gap = 0;
          m_in_gap = 1;
        end
        if (m_in_gap) begin
          if (uart_control[1:0] != m_rate) m_rate_ok = 0;
          if (busy) begin
            m_gap++;
            if (m_gap > 40) begin
              check("gap_timeout", 32'(m_gap), 32'(GAP));
              m_in_gap = 0;
            end
          end else begin
            check("gap_len", 32'(m_gap), 32'(GAP));
            check("rate_frozen", 32'(m_rate_ok), 32'd1);
            m_in_gap = 0;
          end
        end
      end
      m_prev = op;

      if (m_armed) begin
        m_lat++;
        if (!busy) begin
          check("accept_to_idle", 32'(m_lat), 32'(m_exp_lat));
          m_armed = 0;
        end else if (m_lat > 40) begin
          check("busy_timeout", 32'(m_lat), 32'(m_exp_lat));
          m_armed = 0;
        end
      end
      if (cmd_valid && cmd_ready) begin
        m_armed = 1;
        m_lat = 0;
        m_exp_lat = (cmd_op == OP_NOP) ? 1 : 3 + GAP;
      end

      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_data), 32'hFFFF);
        end else begin
          exp_b = rsp_q.pop_front();
          check("rsp_data", 32'(rsp_data), 32'(exp_b));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] rop;
    nReset = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    nReset = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_control", 32'(uart_control), 32'h0);
    check("rst_tx", 32'(uart_tx_data), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data", 32'(rsp_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    @(posedge clk);
    #1;

    // single WRITE 0xA5 at rate 01
    send(OP_WRITE, 8'hA5, 2'b01, 8'h00, 0);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("write_ctrl", 32'(uart_control), 32'h5);
    check("write_tx", 32'(uart_tx_data), 32'hA5);
    wait_idle();

    // READ with held-off consumer
    rr_force = 1'b0;
    send(OP_READ, 8'h00, 2'b01, 8'h3C, 0);
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    check("read_rsp_valid", 32'(rsp_valid), 32'h1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", 32'(rsp_valid), 32'h1);
      check("hold_cmd_ready", 32'(cmd_ready), 32'h0);
      check("hold_no_op", 32'(uart_control[3:2]), 32'h0);
    end
    @(posedge clk);
    #1;
    rr_force = 1'b1;
    @(posedge clk);
    #1;
    rr_force = 1'b0;
    @(negedge clk);
    check("release_rsp_valid", 32'(rsp_valid), 32'h0);
    check("release_cmd_ready", 32'(cmd_ready), 32'h1);
    check("read_rsp_data_held", 32'(rsp_data), 32'h3C);
    rr_force = 1'b1;
    @(posedge clk);
    #1;

    // back-to-back WRITE, WRITE, CLEAR
    send(OP_WRITE, 8'h11, 2'b10, 8'h00, 0);
    send(OP_WRITE, 8'h22, 2'b10, 8'h00, 0);
    send(OP_CLEAR, 8'h99, 2'b10, 8'h00, 0);
    cmd_valid = 1'b0;
    wait_idle();
    check("tx_after_clear", 32'(uart_tx_data), 32'h22);

    // NOP, then READ with rate change while busy
    send(OP_NOP, 8'h00, 2'b01, 8'h00, 0);
    send(OP_READ, 8'h00, 2'b01, 8'hC3, 0);
    cmd_valid = 1'b0;
    rate_sel = 2'b11;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("rate_first_idle", 32'(uart_control[1:0]), 32'h1);
    @(negedge clk);
    check("rate_updated", 32'(uart_control[1:0]), 32'h3);
    wait_idle();

    // reset during HOLD of a READ
    send(OP_READ, 8'h00, 2'b01, 8'h5A, 0);
    cmd_valid = 1'b0;
    @(posedge clk);
    #2;
    nReset = 1'b0;
    #1;
    check("arst_control", 32'(uart_control), 32'h0);
    check("arst_tx", 32'(uart_tx_data), 32'h0);
    check("arst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("arst_rsp_data", 32'(rsp_data), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    rsp_q.delete();
    ops_q.delete();
    rd_q.delete();
    last_wdata = 8'h00;
    last_rd = 8'h00;
    @(posedge clk);
    #3;
    nReset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", 32'(rsp_valid), 32'h0);
    end
    @(posedge clk);
    #1;
    send(OP_WRITE, 8'h6B, 2'b00, 8'h00, 0);
    cmd_valid = 1'b0;
    wait_idle();

    // randomized traffic
    rr_random = 1'b1;
    for (int n = 0; n < 60; n++) begin
      rop = 2'($urandom_range(0, 3));
      send(rop, 8'($urandom), 2'($urandom_range(0, 3)), 8'($urandom), 1);
      if ($urandom_range(0, 3) == 0) begin
        cmd_valid = 1'b0;
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1;
      end
    end
    cmd_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("ops_q_drained", 32'(ops_q.size()), 32'd0);
    check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    check("final_rsp_data", 32'(rsp_data), 32'(last_rd));
    check("final_tx", 32'(uart_tx_data), 32'(last_wdata));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
